// File: rtl/iot_event_arbiter.sv
// -----------------------------------------------------------------------------
// iot_event_arbiter
//
// Round-robin arbiter that funnels connect/disconnect events from N device-side
// requesters onto the single change/on_off event port of the active-IoT-devices
// monitor. Each event is serialised into a one-cycle change pulse, and the
// winning requester gets a one-cycle ack. If the event would push the monitor
// counter past full scale or below zero, the requester gets a one-cycle rej
// instead. A saturating shadow copy of the monitor count is kept here, so that
// saturation can be detected before any event is issued.
//
// Ports
//   clk     in   1      system clock, rising edge
//   rst     in   1      synchronous active-low reset
//   req     in   N      per-requester event request, held until ack or rej
//   dir     in   N      per-requester direction (1 = device on, 0 = device off)
//   ack     out  N      one-cycle accept pulse to the granted requester
//   rej     out  N      one-cycle reject pulse to the granted requester
//   change  out  1      one-cycle event strobe to the monitor
//   on_off  out  1      event direction to the monitor, 0 unless change = 1
//   busy    out  1      high whenever an event is in flight
//   count   out  CNT_W  shadow count of active devices
//
// Event timing (t = edge at which req is sampled in IDLE)
//   accepted : IDLE -> ISSUE (change) -> ACK (ack) -> IDLE      3 cycles
//   rejected : IDLE -> REJECT (rej) -> IDLE                     2 cycles
// -----------------------------------------------------------------------------
module iot_event_arbiter #(
    parameter int N     = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic [N-1:0]     dir,
    output logic [N-1:0]     ack,
    output logic [N-1:0]     rej,
    output logic             change,
    output logic             on_off,
    output logic             busy,
    output logic [CNT_W-1:0] count
);

    localparam int IDX_W = $clog2(N);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUE  = 2'd1,
        S_ACK    = 2'd2,
        S_REJECT = 2'd3
    } state_t;

    // -------------------------------------------------------------------------
    // State and registered outputs
    // -------------------------------------------------------------------------
    state_t           state,      state_nxt;
    logic [IDX_W-1:0] grant,      grant_nxt;
    logic [IDX_W-1:0] rr_ptr,     rr_ptr_nxt;
    logic             dir_lat,    dir_lat_nxt;
    logic [CNT_W-1:0] count_nxt;
    logic [N-1:0]     ack_nxt;
    logic [N-1:0]     rej_nxt;
    logic             change_nxt;
    logic             on_off_nxt;
    logic             busy_nxt;

    // -------------------------------------------------------------------------
    // Round-robin search: the first requester at or above rr_ptr, wrapping
    // modulo N. The candidate sum needs one extra bit so it can be folded back
    // into the range 0..N-1 for non-power-of-two N.
    // -------------------------------------------------------------------------
    logic             found;
    logic [IDX_W-1:0] pick;
    logic [IDX_W:0]   cand_sum;
    logic [IDX_W-1:0] cand;

    always_comb begin
        // NOTE: every variable written here gets a default first, so no path
        // can leave one unassigned and infer a latch.
        found    = 1'b0;
        pick     = '0;
        cand_sum = '0;
        cand     = '0;
        for (int k = 0; k < N; k++) begin
            cand_sum = {1'b0, rr_ptr} + (IDX_W+1)'(k);
            if (cand_sum >= (IDX_W+1)'(N)) begin
                cand_sum = cand_sum - (IDX_W+1)'(N);
            end
            cand = cand_sum[IDX_W-1:0];
            if (!found && req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    // The pointer moves to the slot after the requester just served, so that
    // requester has the lowest priority in the next search.
    logic [IDX_W-1:0] grant_inc;

    always_comb begin
        grant_inc = '0;
        if (grant != IDX_W'(N - 1)) begin
            grant_inc = grant + IDX_W'(1);
        end
    end

    // An event is rejected when applying it would wrap the monitor counter.
    logic sat_hit;

    always_comb begin
        sat_hit = 1'b0;
        if (dir[pick] && (count == {CNT_W{1'b1}})) begin
            sat_hit = 1'b1;
        end
        if (!dir[pick] && (count == '0)) begin
            sat_hit = 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and next-output logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_nxt   = state;
        grant_nxt   = grant;
        rr_ptr_nxt  = rr_ptr;
        dir_lat_nxt = dir_lat;
        count_nxt   = count;

        case (state)
            S_IDLE: begin
                if (found) begin
                    grant_nxt   = pick;
                    dir_lat_nxt = dir[pick];
                    state_nxt   = sat_hit ? S_REJECT : S_ISSUE;
                end
            end
            S_ISSUE: begin
                // count moves on the edge that leaves ISSUE, so the new value
                // is visible in the same cycle as the ack.
                if (dir_lat) begin
                    count_nxt = count + CNT_W'(1);
                end else begin
                    count_nxt = count - CNT_W'(1);
                end
                state_nxt = S_ACK;
            end
            S_ACK: begin
                rr_ptr_nxt = grant_inc;
                state_nxt  = S_IDLE;
            end
            S_REJECT: begin
                rr_ptr_nxt = grant_inc;
                state_nxt  = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        // The outputs are decoded from the next state and registered, so each
        // pulse lines up with the cycle its state occupies, without a
        // combinational path from req to the outputs.
        ack_nxt    = (state_nxt == S_ACK)    ? (N'(1) << grant_nxt) : '0;
        rej_nxt    = (state_nxt == S_REJECT) ? (N'(1) << grant_nxt) : '0;
        change_nxt = (state_nxt == S_ISSUE);
        on_off_nxt = (state_nxt == S_ISSUE) && dir_lat_nxt;
        busy_nxt   = (state_nxt != S_IDLE);
    end

    // -------------------------------------------------------------------------
    // Registers. Reset aborts any event in flight: the pending ack/rej is
    // dropped and the shadow count restarts from zero.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples the pre-edge values of the others.
        if (!rst) begin
            state   <= S_IDLE;
            grant   <= '0;
            rr_ptr  <= '0;
            dir_lat <= 1'b0;
            count   <= '0;
            ack     <= '0;
            rej     <= '0;
            change  <= 1'b0;
            on_off  <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state   <= state_nxt;
            grant   <= grant_nxt;
            rr_ptr  <= rr_ptr_nxt;
            dir_lat <= dir_lat_nxt;
            count   <= count_nxt;
            ack     <= ack_nxt;
            rej     <= rej_nxt;
            change  <= change_nxt;
            on_off  <= on_off_nxt;
            busy    <= busy_nxt;
        end
    end

endmodule

// File: doc/iot_event_arbiter.md
Name: iot_event_arbiter

Overview:
- Round-robin arbiter that shares the single change/on_off event port of the active-IoT-devices monitor between N device requesters.
- Serialises simultaneous device connect/disconnect events into one-cycle change pulses, acknowledges each requester, and keeps a saturating shadow count of active devices.
- Sits between the device-side event sources and the monitor counter; the monitor's change/on_off inputs are driven only by this block.

Parameters:
- N, 4, number of requesters (2..16).
- CNT_W, 8, width of the shadow count; matches the monitor counter width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- req  in  N  per-requester event request; held high until ack or rej.
- dir  in  N  per-requester direction: 1 = device on, 0 = device off; valid while req is high.
- ack  out  N  one-cycle accept pulse to the granted requester.
- rej  out  N  one-cycle reject pulse to the granted requester when the count is saturated.
- change  out  1  one-cycle event strobe to the monitor.
- on_off  out  1  direction to the monitor; valid when change = 1, 0 otherwise.
- busy  out  1  high whenever state != IDLE.
- count  out  CNT_W  shadow count of active devices.

Behaviour:
- All outputs are registered. While rst = 0 at a clock edge, the following are forced to 0: state = IDLE, ack, rej, change, on_off, busy, count, rr_ptr and grant index.
- Reset asserted in any state aborts the event in flight. No ack or rej is issued for an aborted event, and count is cleared.
- FSM states:
  - IDLE: if req != 0 at an edge:
    - grant = first index i with req[i] = 1, searching from rr_ptr upward modulo N.
    - Latch dir[grant].
    - If the latched dir = 1 and count = 2^CNT_W-1, or dir = 0 and count = 0, go to REJECT. Otherwise go to ISSUE.
    - If req = 0, stay in IDLE.
  - ISSUE: change = 1 and on_off = latched dir for exactly this cycle. count is incremented (dir = 1) or decremented (dir = 0) at the edge leaving ISSUE. Next state is ACK.
  - ACK: ack[grant] = 1 for this cycle only. rr_ptr = (grant + 1) mod N at the exit edge. Next state is IDLE.
  - REJECT: rej[grant] = 1 for this cycle only. No change pulse and count is unchanged. rr_ptr advances as in ACK. Next state is IDLE.
- Latency and throughput:
  - req sampled high at edge t gives change high in cycle t..t+1 and ack high in cycle t+1..t+2.
  - An accepted event takes 3 cycles (IDLE, ISSUE, ACK); a rejected event takes 2 cycles (IDLE, REJECT).
- Handshake rules:
  - A requester holds req and dir stable from assertion until it sees ack or rej, then deasserts req in the following cycle.
  - req still high in the IDLE cycle after ack is treated as a new request.
  - req withdrawn before it is granted is ignored; no ack is issued for it.
  - dir changes after the grant edge are ignored, because the direction is latched at grant.
- Fairness: each requester holding req is granted within N events.
- Arithmetic: count never wraps. Saturation is handled only by the REJECT path, so the monitor never receives an event that would overflow or underflow it.
- At most one bit of ack | rej is high in any cycle. change is high only in ISSUE.

Test Plan:
- Reset: hold rst = 0 for 3 cycles with req = 4'b1111 -> all outputs 0, busy = 0; release rst -> first grant goes to index 0.
- Single on-event: req[2] = 1, dir[2] = 1 at count = 0 -> change = 1, on_off = 1 one cycle later; ack[2] one cycle after that; count = 1; busy high for exactly 2 cycles.
- Round-robin: req = 4'b1011 held, each requester reissuing after its ack, all dir = 1 -> grant order 0, 1, 3, 0, 1, 3; count = 6 after 18 cycles.
- Underflow: count = 0, req[1] = 1, dir[1] = 0 -> rej[1] pulses, no change pulse, count stays 0. Overflow: count = 255, dir = 1 -> rej, count stays 255.
- Mixed directions: four on-events from index 0, then two off-events from index 3 -> exactly six change pulses with on_off sequence 1, 1, 1, 1, 0, 0; count = 2.
- Reset mid-event: rst = 0 during the ISSUE cycle -> no ack issued, count = 0, rr_ptr = 0; after release the pending req is re-granted normally.
